// File: rtl/grf_bypass_sb.sv
// General register file with two combinational read ports, two synchronous
// write ports (port 1 wins on address collision), optional write-to-read
// bypass and a per-register busy scoreboard for long-latency producers.
module grf_bypass_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              Clk,
  input  logic              Clr_n,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic              Busy1,
  output logic              Busy2,
  input  logic              WE0,
  input  logic [ADDR_W-1:0] A3_0,
  input  logic [DATA_W-1:0] WD0,
  input  logic              WE1,
  input  logic [ADDR_W-1:0] A3_1,
  input  logic [DATA_W-1:0] WD1,
  input  logic              RsvE,
  input  logic [ADDR_W-1:0] RsvA
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;

  logic we0_ok;
  logic we1_ok;
  logic rsv_ok;

  // Register 0 is hard-wired when ZERO_REG is set: it is never written or reserved.
  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Qualify write and reservation requests against the hard-wired zero register.
  always_comb begin
    we0_ok = WE0 && !is_zero(A3_0);
    we1_ok = WE1 && !is_zero(A3_1);
    rsv_ok = RsvE && !is_zero(RsvA);
  end

  // Next state: port 0 first, then port 1 overrides, then a reservation sets
  // busy last because it belongs to a newer producer than the retiring write.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (we0_ok) begin
      regs_d[A3_0] = WD0;
      busy_d[A3_0] = 1'b0;
    end
    if (we1_ok) begin
      regs_d[A3_1] = WD1;
      busy_d[A3_1] = 1'b0;
    end
    if (rsv_ok) begin
      busy_d[RsvA] = 1'b1;
    end
  end

  // State registers; reset clears every entry and every busy bit and
  // discards anything presented while Clr_n is low.
  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // Read data: zero register first, then same-cycle writes (port 1 before
  // port 0) when bypassing, otherwise the stored value.
  function automatic logic [DATA_W-1:0] rd_data(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] d;
    d = regs_q[a];
    if (is_zero(a)) begin
      d = '0;
    end else if ((BYPASS != 0) && WE1 && (A3_1 == a)) begin
      d = WD1;
    end else if ((BYPASS != 0) && WE0 && (A3_0 == a)) begin
      d = WD0;
    end
    return d;
  endfunction

  // Busy view: a same-cycle write to the register hides its busy bit when
  // bypassing so that Busy and RD never disagree.
  function automatic logic rd_busy(input logic [ADDR_W-1:0] a);
    logic b;
    b = busy_q[a];
    if (is_zero(a)) begin
      b = 1'b0;
    end else if ((BYPASS != 0) && ((WE1 && (A3_1 == a)) || (WE0 && (A3_0 == a)))) begin
      b = 1'b0;
    end
    return b;
  endfunction

  // Combinational read ports.
  always_comb begin
    RD1   = rd_data(A1);
    RD2   = rd_data(A2);
    Busy1 = rd_busy(A1);
    Busy2 = rd_busy(A2);
  end

endmodule

// File: tb/tb_grf_bypass_sb.sv
// Directed bench for grf_bypass_sb: a bypassing instance and a non-bypassing
// instance share all inputs; a per-cycle vector table checks reads and busy
// flags, followed by a mid-run reset sequence and a write/readback pass.
module tb_grf_bypass_sb;

  logic        clk;
  logic        clr_n;
  logic [4:0]  a1, a2;
  logic        we0, we1, rsve;
  logic [4:0]  a3_0, a3_1, rsva;
  logic [31:0] wd0, wd1;

  logic [31:0] rd1, rd2, nb_rd1, nb_rd2;
  logic        busy1, busy2, nb_busy1, nb_busy2;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q[$];

  grf_bypass_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) u_dut (
    .Clk(clk), .Clr_n(clr_n), .A1(a1), .A2(a2), .RD1(rd1), .RD2(rd2),
    .Busy1(busy1), .Busy2(busy2), .WE0(we0), .A3_0(a3_0), .WD0(wd0),
    .WE1(we1), .A3_1(a3_1), .WD1(wd1), .RsvE(rsve), .RsvA(rsva)
  );

  grf_bypass_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) u_dut_nb (
    .Clk(clk), .Clr_n(clr_n), .A1(a1), .A2(a2), .RD1(nb_rd1), .RD2(nb_rd2),
    .Busy1(nb_busy1), .Busy2(nb_busy2), .WE0(we0), .A3_0(a3_0), .WD0(wd0),
    .WE1(we1), .A3_1(a3_1), .WD1(wd1), .RsvE(rsve), .RsvA(rsva)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        we0;
    logic [4:0]  a3_0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  a3_1;
    logic [31:0] wd1;
    logic        rsve;
    logic [4:0]  rsva;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        b1;
    logic        b2;
    logic [31:0] nb_rd1;
    logic        nb_b1;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic we0_v, input logic [4:0] a30, input logic [31:0] wd0_v,
    input logic we1_v, input logic [4:0] a31, input logic [31:0] wd1_v,
    input logic rsve_v, input logic [4:0] rsva_v,
    input logic [4:0] a1_v, input logic [4:0] a2_v,
    input logic [31:0] e_rd1, input logic [31:0] e_rd2,
    input logic e_b1, input logic e_b2,
    input logic [31:0] e_nb_rd1, input logic e_nb_b1);
    vec_t v;
    v.we0 = we0_v; v.a3_0 = a30; v.wd0 = wd0_v;
    v.we1 = we1_v; v.a3_1 = a31; v.wd1 = wd1_v;
    v.rsve = rsve_v; v.rsva = rsva_v;
    v.a1 = a1_v; v.a2 = a2_v;
    v.rd1 = e_rd1; v.rd2 = e_rd2; v.b1 = e_b1; v.b2 = e_b2;
    v.nb_rd1 = e_nb_rd1; v.nb_b1 = e_nb_b1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic idle_inputs();
    we0 = 1'b0; a3_0 = '0; wd0 = '0;
    we1 = 1'b0; a3_1 = '0; wd1 = '0;
    rsve = 1'b0; rsva = '0;
  endtask

  task automatic drive_vec(input vec_t v);
    we0 = v.we0; a3_0 = v.a3_0; wd0 = v.wd0;
    we1 = v.we1; a3_1 = v.a3_1; wd1 = v.wd1;
    rsve = v.rsve; rsva = v.rsva;
    a1 = v.a1; a2 = v.a2;
  endtask

  initial begin
    // Per cycle: wr0(en,a,d) wr1(en,a,d) rsv(en,a) | A1 A2 | RD1 RD2 B1 B2 | nb RD1 nb B1
    vecs[0]  = mk(1,5,32'h0000_1234, 0,0,0, 0,0,  5,0,  32'h0000_1234,0,0,0, 0,0);
    vecs[1]  = mk(1,8,32'hAAAA_0000, 1,8,32'h5555_FFFF, 0,0,  8,5,
                  32'h5555_FFFF,32'h0000_1234,0,0, 0,0);
    vecs[2]  = mk(0,0,0, 0,0,0, 0,0,  8,5,  32'h5555_FFFF,32'h0000_1234,0,0, 32'h5555_FFFF,0);
    vecs[3]  = mk(1,0,32'hDEAD_BEEF, 0,0,0, 1,0,  0,8,  0,32'h5555_FFFF,0,0, 0,0);
    vecs[4]  = mk(0,0,0, 0,0,0, 0,0,  0,0,  0,0,0,0, 0,0);
    vecs[5]  = mk(1,4,32'h11, 0,0,0, 1,9,  4,4,  32'h11,32'h11,0,0, 0,0);
    vecs[6]  = mk(0,0,0, 0,0,0, 0,0,  4,9,  32'h11,0,0,1, 32'h11,0);
    vecs[7]  = mk(0,0,0, 0,0,0, 0,0,  9,9,  0,0,1,1, 0,1);
    vecs[8]  = mk(0,0,0, 1,9,32'h7, 0,0,  9,9,  32'h7,32'h7,0,0, 0,1);
    vecs[9]  = mk(0,0,0, 0,0,0, 0,0,  9,9,  32'h7,32'h7,0,0, 32'h7,0);
    vecs[10] = mk(0,0,0, 0,0,0, 1,12, 12,12, 0,0,0,0, 0,0);
    vecs[11] = mk(1,12,32'h3, 0,0,0, 1,12, 12,12, 32'h3,32'h3,0,0, 0,1);
    vecs[12] = mk(0,0,0, 0,0,0, 0,0,  12,12, 32'h3,32'h3,1,1, 32'h3,1);
    vecs[13] = mk(1,21,32'h0BAD_F00D, 1,20,32'hCAFE_F00D, 0,0,  20,21,
                  32'hCAFE_F00D,32'h0BAD_F00D,0,0, 0,0);
    vecs[14] = mk(0,0,0, 0,0,0, 0,0,  20,21, 32'hCAFE_F00D,32'h0BAD_F00D,0,0, 32'hCAFE_F00D,0);
    vecs[15] = mk(0,0,0, 0,0,0, 1,12, 12,20, 32'h3,32'hCAFE_F00D,1,0, 32'h3,1);
    vecs[16] = mk(0,0,0, 1,12,32'h99, 0,0, 12,12, 32'h99,32'h99,0,0, 32'h3,1);
    vecs[17] = mk(0,0,0, 0,0,0, 0,0,  12,31, 32'h99,0,0,0, 32'h99,0);

    // Reset state
    clr_n = 1'b0;
    idle_inputs();
    a1 = 5'd5; a2 = 5'd31;
    @(negedge clk);
    #1;
    chk("reset rd1", rd1, 32'h0);
    chk("reset rd2", rd2, 32'h0);
    chk("reset busy1", {31'b0, busy1}, 32'h0);
    chk("reset busy2", {31'b0, busy2}, 32'h0);
    @(negedge clk);
    clr_n = 1'b1;

    // Table-driven vectors: one per cycle, checked before the rising edge
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive_vec(vecs[i]);
      #1;
      chk($sformatf("v%0d rd1", i), rd1, vecs[i].rd1);
      chk($sformatf("v%0d rd2", i), rd2, vecs[i].rd2);
      chk($sformatf("v%0d busy1", i), {31'b0, busy1}, {31'b0, vecs[i].b1});
      chk($sformatf("v%0d busy2", i), {31'b0, busy2}, {31'b0, vecs[i].b2});
      chk($sformatf("v%0d nb_rd1", i), nb_rd1, vecs[i].nb_rd1);
      chk($sformatf("v%0d nb_busy1", i), {31'b0, nb_busy1}, {31'b0, vecs[i].nb_b1});
    end

    // Mid-run reset: reg5 holds 0x1234, reserve reg5 so its busy bit is set
    @(negedge clk);
    idle_inputs();
    rsve = 1'b1; rsva = 5'd5;
    a1 = 5'd5; a2 = 5'd5;
    @(negedge clk);
    idle_inputs();
    #1;
    chk("pre-reset rd1", rd1, 32'h0000_1234);
    chk("pre-reset busy1", {31'b0, busy1}, 32'h1);
    clr_n = 1'b0;
    #1;
    chk("async reset rd1", rd1, 32'h0);
    chk("async reset busy1", {31'b0, busy1}, 32'h0);
    chk("async reset nb rd1", nb_rd1, 32'h0);
    // Write and reservation presented during reset: bypass only, nothing stored
    @(negedge clk);
    we0 = 1'b1; a3_0 = 5'd5; wd0 = 32'h77;
    rsve = 1'b1; rsva = 5'd9;
    a2 = 5'd9;
    #1;
    chk("in-reset bypass rd1", rd1, 32'h77);
    chk("in-reset nb rd1", nb_rd1, 32'h0);
    @(negedge clk);
    idle_inputs();
    clr_n = 1'b1;
    #1;
    chk("post-reset rd1", rd1, 32'h0);
    chk("post-reset busy2", {31'b0, busy2}, 32'h0);

    // Write/readback through the expected queue
    for (int i = 1; i <= 6; i++) begin
      logic [31:0] v;
      v = $urandom;
      @(negedge clk);
      idle_inputs();
      if (i % 2 == 0) begin
        we1 = 1'b1; a3_1 = 5'(i); wd1 = v;
      end else begin
        we0 = 1'b1; a3_0 = 5'(i); wd0 = v;
      end
      exp_q.push_back(v);
    end
    @(negedge clk);
    idle_inputs();
    for (int i = 1; i <= 6; i++) begin
      logic [31:0] e;
      @(negedge clk);
      a1 = 5'(i);
      a2 = 5'(i);
      #1;
      e = exp_q.pop_front();
      chk($sformatf("readback r%0d rd1", i), rd1, e);
      chk($sformatf("readback r%0d nb rd2", i), nb_rd2, e);
    end

    // Final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
